// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles every signal between the requesting datapath units, the shared
//   combinational ALU and the arbiter that sequences access to it.
//
//   Request side  : req_valid / req_ready (one bit per requester),
//                   req_op / req_a / req_b (packed, requester i at slice i)
//   ALU side      : alu_operation / alu_a / alu_b (to the ALU),
//                   alu_out / alu_overflow (from the ALU)
//   Response side : rsp_valid / rsp_ready, rsp_id, rsp_result, rsp_overflow
//
//   Modports:
//     slave  - the arbiter (drives req_ready, alu_* operands, rsp_*)
//     master - the environment (requesters, ALU, response consumer)
//
//   Handshakes (both request and response side):
//     A transfer happens on a rising clk edge where valid and ready are both 1.
//     The producer keeps valid and its payload stable until that edge; it may
//     drop valid beforehand to withdraw. ready may depend combinationally on
//     valid; valid never depends on ready.
// ----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [3*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;

  logic [2:0]            alu_operation;
  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [31:0]           alu_out;
  logic                  alu_overflow;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_overflow;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  alu_out, alu_overflow,
    input  rsp_ready,
    output req_ready,
    output alu_operation, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_overflow
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    output alu_out, alu_overflow,
    output rsp_ready,
    input  req_ready,
    input  alu_operation, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_overflow
  );
endinterface

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational 32-bit ALU among NUM_REQ requesters.
//   A round-robin arbiter picks one request in IDLE, registers its op and
//   operands onto the ALU inputs, holds them for SETTLE_CYCLES clocks so the
//   ripple through the ALU has settled, then captures alu_out/alu_overflow and
//   presents them as a valid/ready response tagged with the requester index.
//
// Parameters
//   NUM_REQ        number of requesters (2..8)
//   SETTLE_CYCLES  clocks the operands are held before sampling (>=1)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        alu_arbiter_if.slave: request, ALU and response signals
//   dbg_state  current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//   perf_busy    (ALU_ARB_PERF_EN only) cycles spent outside IDLE, wraps
//   perf_grants  (ALU_ARB_PERF_EN only) per-requester accept counts,
//                requester i at [32i+31:32i], wraps
//
// Optional feature macro: ALU_ARB_PERF_EN (performance counters).
//
// FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE : grant the first valid requester scanning upward from the pointer.
//   EXEC : operands held on the ALU, counter runs down to zero, sample at 0.
//   RESP : response held until rsp_ready; no new grant in the handshake cycle.
// ----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_arbiter_if.slave          bus,
  output logic [1:0]            dbg_state
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]           perf_busy,
  output logic [32*NUM_REQ-1:0] perf_grants
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [IW:0]   NREQ_W   = (IW+1)'(NUM_REQ);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  ptr_q,   ptr_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [2:0]     op_q,    op_d;
  logic [31:0]    a_q,     a_d;
  logic [31:0]    b_q,     b_d;
  logic [IW-1:0]  id_q,    id_d;
  logic [31:0]    res_q,   res_d;
  logic           ovf_q,   ovf_d;

  // Arbitration results
  logic               found;
  logic [IW-1:0]      winner;
  logic [IW:0]        cand;
  logic [IW:0]        ptr_inc;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         sel_op;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic               accept;

  // --------------------------------------------------------------------------
  // Round-robin search: candidate index = ptr + k wrapped at NUM_REQ, so the
  // scan also works when NUM_REQ is not a power of two.
  // --------------------------------------------------------------------------
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!found && bus.req_valid[cand[IW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

  // Payload mux and one-hot grant built from the winner index.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    grant  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IW'(i)) begin
        sel_op = bus.req_op[3*i +: 3];
        sel_a  = bus.req_a[32*i +: 32];
        sel_b  = bus.req_b[32*i +: 32];
      end
      // rst_n gates the grant so nothing looks accepted while reset is held.
      grant[i] = rst_n && (state_q == S_IDLE) && found && (winner == IW'(i));
    end
  end

  assign accept  = (state_q == S_IDLE) && found;
  assign ptr_inc = {1'b0, winner} + (IW+1)'(1);

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    res_d   = res_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = winner;
          ptr_d   = (ptr_inc >= NREQ_W) ? '0 : ptr_inc[IW-1:0];
          cnt_d   = CNT_LOAD;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        // Operands have been stable SETTLE_CYCLES edges when cnt reaches 0.
        if (cnt_q == '0) begin
          res_d   = bus.alu_out;
          ovf_d   = bus.alu_overflow;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  // ALU inputs come straight from the operand registers, so they only change
  // on an accept and keep the last op's values otherwise.
  assign bus.req_ready     = grant;
  assign bus.alu_operation = op_q;
  assign bus.alu_a         = a_q;
  assign bus.alu_b         = b_q;
  assign bus.rsp_valid     = (state_q == S_RESP);
  assign bus.rsp_id        = id_q;
  assign bus.rsp_result    = res_q;
  assign bus.rsp_overflow  = ovf_q;
  assign dbg_state         = state_q;

`ifdef ALU_ARB_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters, free-running and wrapping at 2^32.
  // --------------------------------------------------------------------------
  logic [31:0]           perf_busy_q,   perf_busy_d;
  logic [32*NUM_REQ-1:0] perf_grants_q, perf_grants_d;

  always_comb begin
    perf_busy_d   = perf_busy_q;
    perf_grants_d = perf_grants_q;
    if (state_q != S_IDLE) begin
      perf_busy_d = perf_busy_q + 32'd1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && (winner == IW'(i))) begin
        perf_grants_d[32*i +: 32] = perf_grants_q[32*i +: 32] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_busy_q   <= '0;
      perf_grants_q <= '0;
    end else begin
      perf_busy_q   <= perf_busy_d;
      perf_grants_q <= perf_grants_d;
    end
  end

  assign perf_busy   = perf_busy_q;
  assign perf_grants = perf_grants_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//   Bench for alu_arbiter with NUM_REQ=4, SETTLE_CYCLES=8. Contains a
//   behavioural ALU that the DUT drives, a transaction-level reference model
//   of the arbiter (round-robin pointer, response due time, expected queue),
//   a vector table, hand-written corner sequences and a random phase.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int N = 4;
  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  alu_arbiter_if #(.NUM_REQ(N)) bus ();

`ifdef ALU_ARB_PERF_EN
  logic [31:0]    perf_busy;
  logic [32*N-1:0] perf_grants;
`endif

  alu_arbiter #(
    .NUM_REQ      (N),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_busy  (perf_busy),
    .perf_grants(perf_grants)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference ALU arithmetic ----------------
  function automatic logic [32:0] alu_ref(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      3'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {v, r};
  endfunction

  // The ALU the arbiter is driving.
  assign {bus.alu_overflow, bus.alu_out} = alu_ref(bus.alu_operation, bus.alu_a, bus.alu_b);

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // requester-side stimulus state
  bit          pend [N];
  logic [2:0]  p_op [N];
  logic [31:0] p_a  [N];
  logic [31:0] p_b  [N];
  bit          rsp_rdy;

  // reference model state
  int          m_ptr;
  bit          m_busy;
  int          m_due;
  int          m_id;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  logic        m_ovf;
  logic [31:0] exp_q[$];

  // observed results
  int          rsp_count = 0;
  int          last_id;
  logic [31:0] last_res;
  logic        last_ovf;
  int          gq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]        = pend[i];
      bus.req_op[3*i +: 3]    = p_op[i];
      bus.req_a[32*i +: 32]   = p_a[i];
      bus.req_b[32*i +: 32]   = p_b[i];
    end
    bus.rsp_ready = rsp_rdy;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    pend[i] = 1'b1;
    p_op[i] = op;
    p_a[i]  = a;
    p_b[i]  = b;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_rand_req(input int i);
    set_req(i, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
  endtask

  // One clock: drive at negedge, check against the model, advance the model
  // for whatever the coming rising edge does, then wait for the next negedge.
  task automatic tick();
    int               w;
    int               idx;
    int               act_w;
    logic [N-1:0]     exp_rdy;
    bit               exp_rv;
    logic [32:0]      r;
    drive();
    #1;
    w = -1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && pend[idx]) w = idx;
      end
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));

    exp_rv = m_busy && (cyc >= m_due);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      check("rsp_result", bus.rsp_result, exp_q[0]);
      check("rsp_overflow", 32'(bus.rsp_overflow), 32'(m_ovf));
    end
    check("alu_operation", 32'(bus.alu_operation), 32'(m_op));
    check("alu_a", bus.alu_a, m_a);
    check("alu_b", bus.alu_b, m_b);

    act_w = -1;
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) act_w = i;
    if (act_w >= 0) gq.push_back(act_w);

    if (w >= 0) begin
      m_busy = 1'b1;
      m_due  = cyc + S + 1;
      m_id   = w;
      m_op   = p_op[w];
      m_a    = p_a[w];
      m_b    = p_b[w];
      r      = alu_ref(m_op, m_a, m_b);
      exp_q.push_back(r[31:0]);
      m_ovf  = r[32];
      m_ptr  = (w + 1) % N;
      pend[w] = 1'b0;
    end else if (exp_rv && rsp_rdy) begin
      m_busy   = 1'b0;
      last_id  = int'(bus.rsp_id);
      last_res = bus.rsp_result;
      last_ovf = bus.rsp_overflow;
      void'(exp_q.pop_front());
      rsp_count++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_rsp(input int target, input string name);
    int n;
    n = 0;
    while (rsp_count < target && n < 60) begin
      tick();
      n++;
    end
    if (rsp_count < target) timeout_fail(name);
  endtask

  task automatic drain();
    int n;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    rsp_rdy = 1'b1;
    n = 0;
    while (m_busy && n < 60) begin
      tick();
      n++;
    end
    if (m_busy) timeout_fail("drain");
  endtask

  // Reset applied at a negedge; every output is checked while reset is held
  // with all requests asserted.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_alu_operation", 32'(bus.alu_operation), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_rsp_overflow", 32'(bus.rsp_overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef ALU_ARB_PERF_EN
    check("rst_perf_busy", perf_busy, 32'd0);
    check("rst_perf_grants0", perf_grants[31:0], 32'd0);
`endif
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    rsp_rdy = 1'b0;
    drive();
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_busy = 1'b0;
    m_op   = '0;
    m_a    = '0;
    m_b    = '0;
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          rq;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];
  int   rr_exp[5];

  initial begin
    int tgt;
    int n;
    int g_sum;

    vecs[0] = '{0, 3'd0, 32'd5,         32'd7,         32'd12,        1'b0};
    vecs[1] = '{0, 3'd1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1};
    vecs[2] = '{0, 3'd4, 32'h8000_0000, 32'd1,         32'h0000_0000, 1'b0};
    vecs[3] = '{1, 3'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1};
    vecs[4] = '{2, 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
    vecs[5] = '{3, 3'd3, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
    vecs[6] = '{1, 3'd5, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_FFFF, 1'b0};
    vecs[7] = '{2, 3'd6, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0};
    vecs[8] = '{3, 3'd7, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
    rr_exp  = '{0, 1, 2, 3, 0};

    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      p_op[i] = '0;
      p_a[i]  = '0;
      p_b[i]  = '0;
    end
    rsp_rdy = 1'b0;
    drive();
    @(negedge clk);
    do_reset();

    // ---- table-driven single transactions ----
    for (int v = 0; v < 9; v++) begin
      set_req(vecs[v].rq, vecs[v].op, vecs[v].a, vecs[v].b);
      rsp_rdy = 1'b1;
      tgt = rsp_count + 1;
      run_until_rsp(tgt, "vec_wait");
      check($sformatf("vec%0d_result", v), last_res, vecs[v].res);
      check($sformatf("vec%0d_overflow", v), 32'(last_ovf), 32'(vecs[v].ovf));
      check($sformatf("vec%0d_id", v), 32'(last_id), 32'(vecs[v].rq));
    end

    // ---- round-robin with all requesters continuously valid ----
    do_reset();
    gq.delete();
    for (int i = 0; i < N; i++) set_rand_req(i);
    rsp_rdy = 1'b1;
    n = 0;
    while (gq.size() < 5 && n < 100) begin
      tick();
      for (int i = 0; i < N; i++) if (!pend[i]) set_rand_req(i);
      n++;
    end
    if (gq.size() < 5) begin
      timeout_fail("rr_grants");
    end else begin
      for (int k = 0; k < 5; k++) check($sformatf("rr_grant%0d", k), 32'(gq[k]), 32'(rr_exp[k]));
    end
    drain();

    // ---- response backpressure ----
    do_reset();
    set_req(1, 3'd0, 32'd100, 32'd23);
    rsp_rdy = 1'b0;
    n = 0;
    while (!(m_busy && cyc >= m_due) && n < 40) begin
      tick();
      n++;
    end
    if (!(m_busy && cyc >= m_due)) timeout_fail("bp_rsp_wait");
    set_rand_req(0);
    set_rand_req(2);
    repeat (20) tick();
    check("bp_state_resp", 32'(dbg_state), 32'd2);
    check("bp_result_held", bus.rsp_result, 32'd123);
    rsp_rdy = 1'b1;
    tick();
    gq.delete();
    tick();
    if (gq.size() == 0) timeout_fail("bp_next_grant");
    else check("bp_next_grant", 32'(gq[$]), 32'd2);
    drain();

    // ---- reset in the middle of EXEC ----
    do_reset();
    set_req(1, 3'd0, 32'h1111_1111, 32'h2222_2222);
    rsp_rdy = 1'b1;
    tick();
    repeat (4) tick();
    check("midrst_state_exec", 32'(dbg_state), 32'd1);
    do_reset();
    set_rand_req(0);
    set_rand_req(2);
    gq.delete();
    tick();
    if (gq.size() == 0) timeout_fail("midrst_prio");
    else check("midrst_prio", 32'(gq[$]), 32'd0);
    drain();

    // ---- randomized traffic against the model ----
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) set_rand_req(i);
        else if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    check("rand_some_responses", 32'(rsp_count > 30), 32'd1);

`ifdef ALU_ARB_PERF_EN
    // ---- performance counters: three back-to-back ops ----
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_rand_req(1);
      rsp_rdy = 1'b1;
      tgt = rsp_count + 1;
      run_until_rsp(tgt, "perf_wait");
    end
    g_sum = 0;
    for (int i = 0; i < N; i++) g_sum += int'(perf_grants[32*i +: 32]);
    check("perf_busy", perf_busy, 32'd27);
    check("perf_grants_sum", 32'(g_sum), 32'd3);
    check("perf_grants1", perf_grants[63:32], 32'd3);
`else
    g_sum = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
